posit_to_fp_arbiter: RTL and testbench
======================================

// Module: posit_to_fp_arbiter
// PURPOSE
//  Shares one combinational Posit_to_FP converter between two requesters
//  using round-robin arbitration with valid/ready handshakes. Selected
//  posit word is converted and captured in a 1-entry output register,
//  tagged with the source id. Sits between posit producers (e.g. two
//  accumulator lanes) and the FP consumer. Also counts conversions.
// PARAMETERS
//  N   32  posit and FP word width (bits)
//  E   8   FP exponent width, passed to the Posit_to_FP instance
//  es  3   posit exponent-field width, passed to the Posit_to_FP instance
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  req0_valid  in   1   requester 0 has a posit word
//  req0_data   in   N   requester 0 posit word
//  req0_ready  out  1   requester 0 word accepted this cycle
//  req1_valid  in   1   requester 1 has a posit word
//  req1_data   in   N   requester 1 posit word
//  req1_ready  out  1   requester 1 word accepted this cycle
//  out_valid   out  1   out_data/out_tag hold a converted result
//  out_data    out  N   converted FP word
//  out_tag     out  1   source of out_data (0 = req0, 1 = req1)
//  out_ready   in   1   consumer takes the result this cycle
//  conv_count  out  32  number of accepted conversions since reset
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_tag=0,
//    conv_count=0, last_grant=1 (req0 wins first contention).
//    Pending output is discarded; reset mid-transfer loses it.
//  - Output states: EMPTY (out_valid=0), FULL (out_valid=1).
//  - slot_free = !out_valid | out_ready (same-cycle drain and refill).
//  - Grant: one valid -> that requester; both valid -> requester
//    != last_grant; none -> no grant.
//  - accept = granted & slot_free. reqX_ready = accept & (grant==X);
//    ready is combinational from valid/out_ready, never both high.
//  - On accept: converter input muxed from granted req data;
//    next edge out_data<=conversion, out_tag<=grant, out_valid<=1,
//    last_grant<=grant, conv_count<=conv_count+1 (wraps FFFFFFFF->0).
//  - Latency: accept edge to out_valid = 1 cycle; throughput 1/cycle
//    when out_ready is held high.
//  - FULL & out_ready & !accept -> EMPTY next edge.
//  - FULL & !out_ready -> out_data/out_tag/out_valid held stable; no
//    requester readied; last_grant and conv_count unchanged.
//  - Requester must hold valid/data until ready; data is sampled only
//    on the accepting edge.
//  - No grant (both invalid): last_grant unchanged.
// TESTING
//  1 Reset: assert rst mid-FULL -> out_valid=0, conv_count=0 at once,
//    no clock edge needed; first post-reset contention grants req0.
//  2 Single: req0 0x40000000, out_ready=1 -> next cycle out_valid=1,
//    out_data=0x3F800000, out_tag=0, conv_count=1.
//  3 Contention: both valid each cycle, req0=0x48000000,
//    req1=0xC0000000 -> outputs alternate tag 0/1: 0x40800000,
//    0xBF800000, ... with no bubbles.
//  4 Backpressure: out_ready=0 for 5 cycles while FULL -> out_data
//    stable, req0_ready=req1_ready=0; raise out_ready -> drains and
//    refills same cycle, grant order resumes round-robin.
//  5 Zero/idle: req1 posit 0x00000000 -> out_data=0x00000000, tag=1;
//    then no valids -> out_valid drops after one drained cycle.
//  6 Counter wrap: preload via 2^32 accepts (or force) ->
//    conv_count 0xFFFFFFFF then 0x00000000 on next accept.

Source files
------------

// File: rtl/posit_to_fp_arbiter.sv
// Two-requester round-robin front end sharing one combinational posit -> IEEE
// float converter; the result lands in a 1-entry output register tagged with its source.
module posit_to_fp_arbiter #(
  parameter int N  = 32,
  parameter int E  = 8,
  parameter int es = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_tag,
  input  logic         out_ready,
  output logic [31:0]  conv_count
);

  localparam int FW   = N - 1;
  localparam int M    = N - 1 - E;
  localparam int SW   = 16;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = (1 << E) - 1;

  localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
  localparam logic signed [SW-1:0] BE_MAX = SW'(EMAX);
  localparam logic signed [SW-1:0] BE_ONE = SW'(1);

  typedef struct packed {
    logic                 sgn;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } dec_t;

  // Splits a posit (not zero, not NaR) into sign, power-of-two scale and a
  // left-aligned fraction.
  function automatic dec_t posit_decode(input logic [N-1:0] p);
    dec_t                 d;
    logic [FW-1:0]        body;
    logic [FW-1:0]        t;
    logic                 rb;
    logic                 run_on;
    logic signed [SW-1:0] k;
    logic [es-1:0]        ex;
    int                   m;
    d.sgn  = p[N-1];
    body   = p[N-1] ? (~p[N-2:0] + 1'b1) : p[N-2:0];
    rb     = body[FW-1];
    m      = 0;
    run_on = 1'b1;
    for (int i = FW - 1; i >= 0; i--) begin
      if (run_on && (body[i] == rb)) m = m + 1;
      else run_on = 1'b0;
    end
    k       = rb ? SW'(m - 1) : SW'(-m);
    t       = body << (m + 1);
    ex      = t[FW-1 -: es];
    d.frac  = t << es;
    d.scale = (k <<< es) + $signed({{(SW-es){1'b0}}, ex});
    return d;
  endfunction

  // Round-to-nearest-even of the fraction to M bits; MSB of result is the carry.
  function automatic logic [M:0] round_mant(input logic [FW-1:0] frac);
    logic [M-1:0] mant;
    logic         g;
    logic         s;
    mant = frac[FW-1 -: M];
    g    = frac[FW-1-M];
    s    = |frac[FW-2-M:0];
    return {1'b0, mant} + (M+1)'(g & (s | mant[0]));
  endfunction

  // Out-of-range scales saturate to the largest finite value or flush to signed zero.
  function automatic logic [N-1:0] fp_pack(input logic sgn,
                                            input logic signed [SW-1:0] be,
                                            input logic [M-1:0] mant);
    if (be >= BE_MAX) return {sgn, E'(EMAX - 1), {M{1'b1}}};
    if (be < BE_ONE)  return {sgn, {(N-1){1'b0}}};
    return {sgn, be[E-1:0], mant};
  endfunction

  function automatic logic [N-1:0] posit_to_fp(input logic [N-1:0] p);
    dec_t                 d;
    logic [M:0]           r;
    logic signed [SW-1:0] be;
    if (p == '0) return '0;
    if (p == {1'b1, {(N-1){1'b0}}}) return {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    d  = posit_decode(p);
    r  = round_mant(d.frac);
    be = d.scale + BIAS_S + $signed({{(SW-1){1'b0}}, r[M]});
    return fp_pack(d.sgn, be, r[M-1:0]);
  endfunction

  logic         last_grant;
  logic         grant_p0;
  logic         granted_p0;
  logic         slot_free_p0;
  logic         accept_p0;
  logic [N-1:0] sel_p0;
  logic [N-1:0] conv_p0;

  // Stage p0: arbitration, handshake and combinational conversion
  always_comb begin
    granted_p0   = req0_valid | req1_valid;
    grant_p0     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    slot_free_p0 = ~out_valid | out_ready;
    accept_p0    = granted_p0 & slot_free_p0;
    req0_ready   = accept_p0 & ~grant_p0;
    req1_ready   = accept_p0 & grant_p0;
    sel_p0       = grant_p0 ? req1_data : req0_data;
    conv_p0      = posit_to_fp(sel_p0);
  end

  // Stage p1: output register, arbitration history and conversion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= 1'b0;
      conv_count <= '0;
      last_grant <= 1'b1;
    end else if (accept_p0) begin
      out_valid  <= 1'b1;
      out_data   <= conv_p0;
      out_tag    <= grant_p0;
      last_grant <= grant_p0;
      conv_count <= conv_count + 32'd1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_to_fp_arbiter.sv
// Directed bench for posit_to_fp_arbiter: handshake, round-robin order,
// backpressure, conversion corner cases, async reset and counter wrap.
module tb_posit_to_fp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, out_ready;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, out_valid, out_tag;
  logic [31:0] out_data, conv_count;

  int compared   = 0;
  int mismatched = 0;

  posit_to_fp_arbiter #(.N(32), .E(8), .es(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_in  [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h4000000C,
                               32'h40000004, 32'h38000000, 32'hFFFFFFFF};
  logic [31:0] vec_out [6] = '{32'h7F7FFFFF, 32'h7FC00000, 32'h3F800002,
                               32'h3F800000, 32'h3E800000, 32'h80000000};

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_tag", {31'd0, out_tag}, 32'd0);
    check("rst_count", conv_count, 32'd0);

    // single request
    req0_valid = 1'b1; req0_data = 32'h40000000; out_ready = 1'b1;
    #1;
    check("single_r0", {31'd0, req0_ready}, 32'd1);
    check("single_r1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", out_data, 32'h3F800000);
    check("single_tag", {31'd0, out_tag}, 32'd0);
    check("single_count", conv_count, 32'd1);

    // contention: last grant was req0, so req1 wins first
    req0_valid = 1'b1; req0_data = 32'h48000000;
    req1_valid = 1'b1; req1_data = 32'hC0000000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_r1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_r0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("cont_valid", {31'd0, out_valid}, 32'd1);
      check("cont_tag", {31'd0, out_tag}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_data", out_data, (i % 2 == 0) ? 32'hBF800000 : 32'h40800000);
      check("cont_count", conv_count, 32'(2 + i));
    end

    // backpressure while FULL with tag 0 / 4.0
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_r0", {31'd0, req0_ready}, 32'd0);
      check("bp_r1", {31'd0, req1_ready}, 32'd0);
      tick();
      check("bp_data", out_data, 32'h40800000);
      check("bp_tag", {31'd0, out_tag}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_count", conv_count, 32'd5);
    end
    out_ready = 1'b1;
    #1;
    check("resume_r1", {31'd0, req1_ready}, 32'd1);
    tick();
    check("resume_tag1", {31'd0, out_tag}, 32'd1);
    check("resume_data1", out_data, 32'hBF800000);
    check("resume_count1", conv_count, 32'd6);
    tick();
    check("resume_tag0", {31'd0, out_tag}, 32'd0);
    check("resume_data0", out_data, 32'h40800000);
    check("resume_count0", conv_count, 32'd7);

    // zero posit from req1, then idle
    req0_valid = 1'b0; req1_data = 32'h00000000;
    #1;
    check("zero_r1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check("zero_data", out_data, 32'h00000000);
    check("zero_tag", {31'd0, out_tag}, 32'd1);
    check("zero_count", conv_count, 32'd8);
    tick();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_count", conv_count, 32'd8);

    // conversion corners: saturation, NaR, rounding ties, small scale, underflow
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_data = vec_in[i];
      tick();
      check("vec_data", out_data, vec_out[i]);
      check("vec_count", conv_count, 32'(9 + i));
    end
    req0_valid = 1'b0;

    // async reset while FULL, checked before any clock edge
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_count", conv_count, 32'd0);
    check("async_data", out_data, 32'd0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h48000000;
    req1_valid = 1'b1; req1_data = 32'hC0000000;
    #1;
    check("postrst_r0", {31'd0, req0_ready}, 32'd1);
    check("postrst_r1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("postrst_tag", {31'd0, out_tag}, 32'd0);
    check("postrst_count", conv_count, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // counter wrap
    force dut.conv_count = 32'hFFFFFFFE;
    #1;
    release dut.conv_count;
    #1;
    req0_valid = 1'b1; req0_data = 32'h40000000;
    tick();
    check("wrap_max", conv_count, 32'hFFFFFFFF);
    tick();
    check("wrap_zero", conv_count, 32'h00000000);
    req0_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
